// File: rtl/icram_pipe.sv
// icram_pipe: line-addressed I-cache data RAM with half-line writes, registered write-first reads and a post-reset clear sweep.
// Optional per-byte even parity when ICRAM_PARITY_EN is defined; the read data port is named dout.
module icram_pipe #(
  parameter int ADR_W = 6,
  parameter int DW = 64,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADR_W-1:0] adr,
  input  logic [DW/2-1:0]  di,
  input  logic [1:0]       we,
  input  logic             enable,
  input  logic             par_flip,
  output logic [DW-1:0]    dout,
  output logic             rd_valid,
  output logic             init_done,
  output logic             par_err
);
  localparam int DEPTH = 2**ADR_W;
  localparam int NB = DW/8;
  localparam int HW = DW/2;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_n;
  logic [ADR_W-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_line, wr_line, fwd_line;
  logic [ADR_W-1:0] wr_adr;
  logic [1:0] wr_en;
  logic access, par_err_n;
  always_comb begin
    state_n = (state == INIT && ptr == '1) ? RUN : state;
    access = state == RUN && enable;
    wr_adr = state == INIT ? ptr : adr;
    wr_en = state == INIT ? 2'b11 : (access ? we : 2'b00);
    wr_line = state == INIT ? {NB{INIT_VAL}} : {di, di};
    rd_line = mem[adr];
    fwd_line = {we[1] ? di : rd_line[DW-1:HW], we[0] ? di : rd_line[HW-1:0]};
  end
  assign init_done = state == RUN;
  always_ff @(posedge clk) begin
    if (wr_en[1]) mem[wr_adr][DW-1:HW] <= wr_line[DW-1:HW];
    if (wr_en[0]) mem[wr_adr][HW-1:0] <= wr_line[HW-1:0];
  end
`ifdef ICRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rd_par, wr_par, mism;
  logic flip;
  always_comb begin
    flip = state == RUN && par_flip;
    rd_par = par[adr];
    wr_par = '0;
    mism = '0;
    for (int j = 0; j < NB; j++) begin
      wr_par[j] = (^wr_line[8*j +: 8]) ^ flip;
      mism[j] = rd_par[j] ^ (^rd_line[8*j +: 8]);
    end
    // freshly written halves are forwarded with good parity, so mask them out
    par_err_n = |(mism & {{(NB/2){~we[1]}}, {(NB/2){~we[0]}}});
  end
  always_ff @(posedge clk) begin
    if (wr_en[1]) par[wr_adr][NB-1:NB/2] <= wr_par[NB-1:NB/2];
    if (wr_en[0]) par[wr_adr][NB/2-1:0] <= wr_par[NB/2-1:0];
  end
`else
  logic unused_par_flip;
  assign unused_par_flip = par_flip;
  assign par_err_n = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      ptr <= '0;
      dout <= '0;
      rd_valid <= 1'b0;
      par_err <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= state == INIT ? ptr + 1'b1 : ptr;
      rd_valid <= access;
      if (access) begin
        dout <= fwd_line;
        par_err <= par_err_n;
      end
    end
  end
endmodule

// File: tb/tb_icram_pipe.sv
// tb_icram_pipe: random and directed stimulus against a behavioural line-memory model of icram_pipe.
module tb_icram_pipe;
  logic clk = 0, reset = 1, enable = 0, par_flip = 0;
  logic [5:0] adr = 0;
  logic [31:0] di = 0;
  logic [1:0] we = 0;
  logic [63:0] dout;
  logic rd_valid, init_done, par_err;
  int checks = 0, errors = 0;
  logic chk_en = 0;
  logic [63:0] m_mem [64];
  logic [7:0] m_bad [64];
  logic [63:0] exp_do;
  logic exp_v, exp_pe, m_done;
  int sweep_cnt;

  icram_pipe dut (.clk(clk), .reset(reset), .adr(adr), .di(di), .we(we), .enable(enable),
                  .par_flip(par_flip), .dout(dout), .rd_valid(rd_valid), .init_done(init_done),
                  .par_err(par_err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // reference: a sweep of 64 clears after reset, then a plain line memory with per-byte bad-parity flags
  always @(posedge clk) begin
    if (reset) begin
      exp_do = 0; exp_v = 0; exp_pe = 0; sweep_cnt = 0; m_done = 0;
    end else if (!m_done) begin
      m_mem[sweep_cnt] = 64'h0;
      m_bad[sweep_cnt] = 8'h0;
      sweep_cnt++;
      m_done = sweep_cnt == 64;
      exp_v = 0;
    end else if (enable) begin
      exp_do = {we[1] ? di : m_mem[adr][63:32], we[0] ? di : m_mem[adr][31:0]};
`ifdef ICRAM_PARITY_EN
      exp_pe = |(m_bad[adr] & {{4{~we[1]}}, {4{~we[0]}}});
`else
      exp_pe = 0;
`endif
      if (we[1]) begin m_mem[adr][63:32] = di; m_bad[adr][7:4] = {4{par_flip}}; end
      if (we[0]) begin m_mem[adr][31:0] = di; m_bad[adr][3:0] = {4{par_flip}}; end
      exp_v = 1;
    end else exp_v = 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", dout, exp_do);
      chk("rd_valid", {63'h0, rd_valid}, {63'h0, exp_v});
      chk("init_done", {63'h0, init_done}, {63'h0, m_done});
      chk("par_err", {63'h0, par_err}, {63'h0, exp_pe});
    end
  end

  task automatic op(input logic e, input logic [5:0] a, input logic [1:0] w, input logic [31:0] d, input logic f);
    enable = e; adr = a; we = w; di = d; par_flip = f;
    @(negedge clk);
  endtask

  task automatic sweep_wait();
    for (int i = 1; i <= 64; i++) begin
      op(0, 0, 0, 0, 0);
      if (i == 63) chk("init_low_63", {63'h0, init_done}, 64'h0);
      if (i == 64) chk("init_high_64", {63'h0, init_done}, 64'h1);
    end
  endtask

  initial begin
    reset = 1;
    @(negedge clk);
    chk_en = 1;
    chk("reset_dout", dout, 64'h0);
    chk("reset_valid", {63'h0, rd_valid}, 64'h0);
    reset = 0;
    sweep_wait();
    op(1, 7, 0, 0, 0);
    chk("clear_read", dout, 64'h0);
    chk("clear_valid", {63'h0, rd_valid}, 64'h1);
    op(1, 5, 2'b10, 32'hDEADBEEF, 0);
    op(1, 5, 2'b01, 32'h01234567, 0);
    op(1, 5, 2'b00, 0, 0);
    chk("halves", dout, 64'hDEADBEEF01234567);
    op(0, 5, 2'b00, 0, 0);
    chk("valid_pulse", {63'h0, rd_valid}, 64'h0);
    op(1, 9, 2'b10, 32'h11111111, 0);
    op(1, 9, 2'b01, 32'h22222222, 0);
    op(1, 9, 2'b01, 32'hAAAAAAAA, 0);
    chk("write_first", dout, 64'h11111111AAAAAAAA);
    op(1, 63, 2'b11, 32'hCAFEF00D, 0);
    op(1, 63, 2'b00, 0, 0);
    chk("both_halves", dout, 64'hCAFEF00DCAFEF00D);
    repeat (3) op(0, 12, 2'b11, 32'h5555AAAA, 0);
    chk("hold_dout", dout, 64'hCAFEF00DCAFEF00D);
    chk("hold_valid", {63'h0, rd_valid}, 64'h0);
    op(1, 2, 2'b10, 32'h12345678, 1);
    chk("par_fwd", {63'h0, par_err}, 64'h0);
    op(1, 2, 2'b00, 0, 0);
`ifdef ICRAM_PARITY_EN
    chk("par_bad", {63'h0, par_err}, 64'h1);
`else
    chk("par_off", {63'h0, par_err}, 64'h0);
`endif
    op(1, 2, 2'b10, 32'h12345678, 0);
    op(1, 2, 2'b00, 0, 0);
    chk("par_fixed", {63'h0, par_err}, 64'h0);
    for (int i = 0; i < 400; i++)
      op($urandom_range(0, 3) != 0, 6'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3) == 0);
    op(1, 30, 2'b11, 32'h3C3C3C3C, 0);
    op(1, 30, 2'b00, 0, 0);
    chk("line30_set", dout, 64'h3C3C3C3C3C3C3C3C);
    reset = 1; enable = 0;
    @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midsweep_dout", dout, 64'h0);
    reset = 0;
    sweep_wait();
    op(1, 30, 2'b00, 0, 0);
    chk("line30_cleared", dout, 64'h0);
    for (int i = 0; i < 200; i++)
      op($urandom_range(0, 3) != 0, 6'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3) == 0);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icram_pipe.md
Name: icram_pipe

Overview:
- Parametrised successor to the single-port instruction-cache data RAM.
- Line-addressed storage: full-line (DW-bit) reads, half-line writes selected by we[1:0]. Both halves may be written in the same cycle.
- Adds a registered read port with a valid strobe, write-first same-address behaviour, and a post-reset clear sweep.
- Sits between the I-cache controller (fill writes) and the fetch/prefetch buffer (line reads).

Parameters:
ADR_W, 6, line address width; depth = 2**ADR_W lines (default 64 lines x 8 bytes = 512 bytes)
DW, 64, read line width in bits; multiple of 16; write half width = DW/2
INIT_VAL, 0, value written to every byte during the reset clear sweep (8 bits)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
adr  input  ADR_W  line address for read and write
di  input  DW/2  write data for the selected half(s)
we  input  2  we[1] writes the upper half (bytes 0..DW/16-1, do[DW-1:DW/2]); we[0] writes the lower half
enable  input  1  access strobe; no read or write when low
par_flip  input  1  test only: inverts the stored parity of bytes written this cycle
do  output  DW  registered read data; byte 0 is do[DW-1:DW-8] (big-endian)
rd_valid  output  1  one-cycle pulse: do updated this cycle
init_done  output  1  high once the clear sweep is complete
par_err  output  1  registered with do; parity mismatch on the line read

Behaviour:
- Reset (reset high at posedge): do=0, rd_valid=0, par_err=0, init_done=0, sweep pointer=0; FSM -> INIT.
- FSM, two states:
  - INIT: each cycle writes INIT_VAL to every byte of line[ptr] (with correct parity), then ptr++. adr/di/we/enable are ignored; rd_valid stays 0.
  - Exit INIT when ptr wraps from 2**ADR_W-1; init_done goes high the following cycle. Sweep takes exactly 2**ADR_W cycles after reset deasserts.
  - RUN: normal operation.
  - Reset asserted in any state, including mid-sweep, restarts INIT from ptr=0.
- Write (RUN, enable=1):
  - we[1]: upper half of line[adr] <= di.
  - we[0]: lower half of line[adr] <= di.
  - we=2'b11: both halves get the same di.
  - we=2'b00 with enable=1: read only.
- Read (RUN, enable=1, any we):
  - do <= line[adr] at the next posedge (latency 1); rd_valid=1 for that cycle.
  - Write-first: halves written in the same cycle appear in do with the new di; unwritten halves return stored data.
- enable=0 or INIT: do holds its previous value; rd_valid=0; par_err holds.
- Address width: adr is exactly ADR_W bits; there is no out-of-range address. X/unknown addresses are not modelled.
- Byte order within a half: di[DW/2-1:DW/2-8] goes to the lowest byte index of that half.

Optional Feature:
- Macro: ICRAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte.
  - par_flip=1 during a write stores the inverted parity for every byte written that cycle.
  - On a read, par_err <= OR of the per-byte mismatches across the line, with the same timing as do.
  - Write-first forwarded bytes use freshly computed parity, so par_err=0 for those bytes; the corruption is only seen on a later read.
  - The INIT sweep writes correct parity.
- Undefined:
  - No parity storage; par_flip is ignored; par_err is tied 0.

Test Plan:
- Reset then idle (default parameters) -> init_done low for 64 cycles, high on cycle 65; a read of any line returns do=0 with rd_valid=1.
- Reset mid-sweep at cycle 20 -> sweep restarts; init_done rises 64 cycles after the second reset deasserts; line 30 previously written with data is cleared.
- adr=5, we=2'b10, di=32'hDEADBEEF; then adr=5, we=2'b01, di=32'h01234567; then read adr=5 -> do=64'hDEADBEEF01234567, rd_valid pulses one cycle.
- Same-cycle write+read: line 9 holds 64'h1111111122222222; enable=1, adr=9, we=2'b01, di=32'hAAAAAAAA -> next cycle do=64'h11111111AAAAAAAA.
- we=2'b11, adr=63, di=32'hCAFEF00D -> read adr=63 gives 64'hCAFEF00DCAFEF00D; then enable=0 for 3 cycles -> do unchanged, rd_valid=0.
- ICRAM_PARITY_EN defined: write adr=2, we=2'b10, par_flip=1 -> immediate write-first read gives par_err=0; a later read of adr=2 gives par_err=1; rewrite with par_flip=0 and read -> par_err=0. Macro undefined: par_err stays 0 throughout.
